lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit that drives the core's word-wide RAM data port: addr2/we2/wd2/rd2. Read is combinational; write commits on the clk rising edge.
- Accepts byte, halfword and word load/store requests from the execute stage.
- Performs lane extraction and sign/zero extension for loads.
- Sub-word stores use a read-modify-write sequence, because the RAM port has only a full-word write enable.
- Little-endian: byte 0 is bits 7:0.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses
RESET_PC_UNUSED, none — no other parameters; data width fixed at 32

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data (low bits used for B/H)
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  32  extended load data (0 for stores)
resp_err  out  1  misaligned access
mem_addr  out  ADDR_WIDTH  word-aligned address to RAM (low 2 bits 0)
mem_we  out  1  RAM write enable
mem_wd  out  32  RAM write data
mem_rd  in  32  RAM combinational read data

Behaviour:
- Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0, req_ready=1.
- mem_we is decoded from state only; reset deasserts it immediately.
- Handshake: request accepted on a rising edge when req_valid && req_ready. Request fields are registered.
- Requests are ignored while busy.
- Response is held stable until resp_valid && resp_ready; then the unit returns to IDLE.
- States:
  - IDLE: accept the request and go to the next state as follows.
    - Misaligned: RESP with err.
    - Load: LOAD.
    - Word store: WRITE.
    - B/H store: RMW_RD.
  - LOAD: mem_addr = {addr[hi:2],2'b00}, mem_we=0. Capture extracted, extended mem_rd into resp_rdata. Go to RESP.
  - RMW_RD: same addressing. Merge req_wdata byte/halfword lanes into mem_rd and register as merge word. Go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle; mem_wd = merge word or req_wdata. Go to RESP.
  - RESP: resp_valid=1.
- Latency with resp_ready=1:
  - Load: resp_valid 2 cycles after accept.
  - SW: 2 cycles after accept.
  - SB/SH: 3 cycles after accept.
  - Error: 1 cycle after accept.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0. It produces no RAM access, resp_err=1 and resp_rdata=0.
- Undefined funct3 values (011, 110, 111) are treated as W.
- Lane selection uses addr[1:0] for B and addr[1] for H.
- Extension: B/H sign-extend; BU/HU zero-extend.
- Back-to-back operation: a new request can be accepted in the cycle after RESP completes. No request overlap.
- Reset mid-operation: abandon the operation and deassert mem_we at once. A pending RMW never writes.

Optional Feature:
LSU_MISALIGN_ERR_EN
- Defined: misaligned requests behave as above (resp_err=1, no access).
- Undefined: no misalignment check and resp_err is tied to 0. Address low bits are forced to natural alignment (H clears bit 0, W clears bits 1:0), and the access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 width-code localparams/enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - the state enum (IDLE, LOAD, RMW_RD, WRITE, RESP);
  - a byte-lane mask helper function.
- One combinational sub-module, lsu_lane_align, with two functions:
  - extract/extend for loads;
  - merge for stores.
  - Inputs: word, addr[1:0], funct3, wdata.
  - Outputs: load_data, merged_word.

Test Plan:
- LW from addr 0, RAM word 0 = 0x76543210 → resp_rdata=0x76543210, resp_err=0, resp_valid 2 cycles after accept.
- RAM word 4 = 0x000080FF. Expected loads:
  - LB addr 4 → 0xFFFFFFFF
  - LBU addr 5 → 0x00000080
  - LH addr 4 → 0xFFFF80FF
  - LHU addr 4 → 0x000080FF
  - LB addr 3 (word 0) → 0x00000076
- Sub-word stores on word 0 (0x76543210):
  - SB addr 1, wdata 0xDEADBEAA → RAM word 0 = 0x7654AA10; exactly one mem_we cycle at mem_addr 0.
  - Then SH addr 2, wdata 0x1234BEEF → 0xBEEFAA10.
  - Then SW addr 0, wdata 0x12345678 → 0x12345678.
- LW addr 2 and LH addr 1:
  - LSU_MISALIGN_ERR_EN defined → resp_err=1, resp_rdata=0, mem_we never high, response 1 cycle after accept.
  - Undefined → LW addr 2 returns word 0.
- Back-pressure: hold resp_ready=0 for 5 cycles after an LW → resp_valid and resp_rdata stable, req_ready=0, a second req_valid is ignored. Release → response consumed, req_ready=1 the next cycle.
- Assert rst_n=0 mid-cycle during RMW_RD of SB addr 0, wdata 0x55 → mem_we stays 0, RAM word unchanged, all outputs at reset values. After release, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states and
// the byte-lane mask helper used by sub-word stores.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } lsu_state_e;

   // One bit per byte of the 32-bit word touched by an access of this width.
   function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (funct3)
         LSU_B, LSU_BU: m = 4'b0001 << addr_lo;
         LSU_H, LSU_HU: m = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:       m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// merging of byte/halfword store data into a word read from RAM.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f);
      logic [31:0]        sh;
      logic [15:0]        h;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      logic signed [31:0] ext;
      sh  = w >> {a, 3'b000};
      h   = a[1] ? w[31:16] : w[15:0];
      b_s = sh[7:0];
      h_s = h;
      case (f)
         LSU_B: begin
            ext = b_s;
            return ext;
         end
         LSU_H: begin
            ext = h_s;
            return ext;
         end
         LSU_BU:  return {24'b0, sh[7:0]};
         LSU_HU:  return {16'b0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] f, input logic [31:0] wd);
      logic [3:0]  m;
      logic [31:0] rep;
      logic [31:0] res;
      m = lane_mask(f, a);
      case (f)
         LSU_B, LSU_BU: rep = {4{wd[7:0]}};
         LSU_H, LSU_HU: rep = {2{wd[15:0]}};
         default:       rep = wd;
      endcase
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = m[i] ? rep[8*i +: 8] : w[8*i +: 8];
      end
      return res;
   endfunction

   assign load_data   = extract(word, addr_lo, funct3);
   assign merged_word = merge(word, addr_lo, funct3, wdata);

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-wide RAM port; sub-word stores use read-modify-write.
// Build option: define LSU_MISALIGN_ERR_EN to report misaligned accesses as errors.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [31:0]           mem_wd,
   input  logic [31:0]           mem_rd
);

   lsu_state_e            state, state_nxt;
   logic                  accept;
   logic                  misalign;
   logic [2:0]            funct3_in;
   logic [ADDR_WIDTH-1:0] addr_in;

   logic [ADDR_WIDTH-1:0] addr_p0;
   logic [2:0]            funct3_p0;
   logic [31:0]           wdata_p0;
   logic [31:0]           merge_p0;

   logic [31:0]           load_data;
   logic [31:0]           merged_word;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // Request decode: unknown width codes behave as W.
   always_comb begin
      funct3_in = req_funct3;
      if (!(req_funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU})) funct3_in = LSU_W;
      addr_in  = req_addr;
      misalign = 1'b0;
`ifdef LSU_MISALIGN_ERR_EN
      case (funct3_in)
         LSU_H, LSU_HU: misalign = req_addr[0];
         LSU_W:         misalign = |req_addr[1:0];
         default:       ;
      endcase
`else
      case (funct3_in)
         LSU_H, LSU_HU: addr_in[0]   = 1'b0;
         LSU_W:         addr_in[1:0] = 2'b00;
         default:       ;
      endcase
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misalign)                state_nxt = RESP;
               else if (!req_we)            state_nxt = LOAD;
               else if (funct3_in == LSU_W) state_nxt = WRITE;
               else                         state_nxt = RMW_RD;
            end
         end
         LOAD:    state_nxt = RESP;
         RMW_RD:  state_nxt = WRITE;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            resp_rdata <= '0;
            resp_err   <= misalign;
         end else if (state == LOAD) begin
            resp_rdata <= load_data;
         end
      end
   end

   // Request fields and RMW merge word; only observed outside IDLE.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0   <= addr_in;
         funct3_p0 <= funct3_in;
         wdata_p0  <= req_wdata;
      end
      if (state == RMW_RD) merge_p0 <= merged_word;
   end

   lsu_lane_align u_lane_align (
      .word        (mem_rd),
      .addr_lo     (addr_p0[1:0]),
      .funct3      (funct3_p0),
      .wdata       (wdata_p0),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // RAM port decoded from state alone so reset drops mem_we immediately.
   always_comb begin
      mem_we     = (state == WRITE);
      resp_valid = (state == RESP);
      mem_addr   = '0;
      mem_wd     = '0;
      if (state inside {LOAD, RMW_RD, WRITE}) mem_addr = {addr_p0[ADDR_WIDTH-1:2], 2'b00};
      if (state == WRITE) mem_wd = (funct3_p0 == LSU_W) ? wdata_p0 : merge_p0;
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised bench for lsu_mem_port against a byte-addressed behavioural model.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] ram [16];
   logic [7:0]  mb  [64];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   assign mem_rd = ram[mem_addr[5:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mword(input int w);
      return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
   endfunction

   // Reference: byte-wise little-endian memory, widths from funct3.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output bit err,
                        output int lat, output bit st, output logic [31:0] waddr,
                        output logic [31:0] wword);
      int     sz;
      int     a;
      bit     sgn;
      longint v;
      rdata = '0; err = 1'b0; st = 1'b0; waddr = '0; wword = '0; lat = 2;
      case (f3)
         3'b000, 3'b100: sz = 1;
         3'b001, 3'b101: sz = 2;
         default:        sz = 4;
      endcase
      sgn = (f3 == 3'b000) || (f3 == 3'b001);
      a   = int'(addr[5:0]);
      if (a % sz != 0) begin
`ifdef LSU_MISALIGN_ERR_EN
         err = 1'b1;
         lat = 1;
         return;
`else
         a = a - (a % sz);
`endif
      end
      waddr = 32'(a - (a % 4));
      if (!we) begin
         v = 0;
         for (int i = 0; i < sz; i++) v += longint'(mb[a+i]) << (8*i);
         if (sgn && v >= (longint'(1) << (8*sz-1))) v -= longint'(1) << (8*sz);
         rdata = v[31:0];
      end else begin
         for (int i = 0; i < sz; i++) mb[a+i] = wd[8*i +: 8];
         st    = 1'b1;
         lat   = (sz == 4) ? 2 : 3;
         wword = mword(a / 4);
      end
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_resp_err"},   resp_err,   0);
      chk({tag, "_mem_we"},     mem_we,     0);
      chk({tag, "_mem_addr"},   mem_addr,   0);
      chk({tag, "_mem_wd"},     mem_wd,     0);
      chk({tag, "_req_ready"},  req_ready,  1);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input bit pin,
                         input logic [31:0] lit);
      logic [31:0] e_rdata, e_waddr, e_wd;
      bit          e_err, e_st;
      int          e_lat;
      model(we, f3, addr, wd, e_rdata, e_err, e_lat, e_st, e_waddr, e_wd);
      if (pin) chk("model_pin", e_st ? e_wd : e_rdata, lit);
      resp_ready = (hold == 0);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= e_lat + hold + 1; c++) begin
         @(negedge clk);
         chk("resp_valid", resp_valid, (c >= e_lat) && (c <= e_lat + hold));
         if (resp_valid) begin
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("resp_err", resp_err, e_err);
         end
         chk("mem_we", mem_we, e_st && (c == e_lat - 1));
         if (mem_we) begin
            chk("mem_addr", mem_addr, e_waddr);
            chk("mem_wd", mem_wd, e_wd);
         end
         chk("req_ready", req_ready, c == e_lat + hold + 1);
         if (c >= e_lat && c < e_lat + hold) begin
            req_valid  = 1'b1;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom_range(0, 63);
            req_wdata  = $urandom;
         end else if (c == e_lat + hold) begin
            req_valid  = 1'b0;
            resp_ready = 1'b1;
         end
      end
      if (e_st) chk("ram_word", ram[e_waddr[5:2]], e_wd);
   endtask

   initial begin
      logic [31:0] before_word;
      @(negedge clk);
      reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int w = 0; w < 16; w++) do_req(1'b1, 3'b010, 32'(4*w), $urandom, 0, 1'b0, 0);
      do_req(1'b1, 3'b010, 0, 32'h7654_3210, 0, 1'b1, 32'h7654_3210);
      do_req(1'b1, 3'b010, 4, 32'h0000_80FF, 0, 1'b1, 32'h0000_80FF);

      do_req(1'b0, 3'b010, 0, 0, 0, 1'b1, 32'h7654_3210);
      do_req(1'b0, 3'b000, 4, 0, 0, 1'b1, 32'hFFFF_FFFF);
      do_req(1'b0, 3'b100, 5, 0, 0, 1'b1, 32'h0000_0080);
      do_req(1'b0, 3'b001, 4, 0, 0, 1'b1, 32'hFFFF_80FF);
      do_req(1'b0, 3'b101, 4, 0, 0, 1'b1, 32'h0000_80FF);
      do_req(1'b0, 3'b000, 3, 0, 0, 1'b1, 32'h0000_0076);

      do_req(1'b1, 3'b000, 1, 32'hDEAD_BEAA, 0, 1'b1, 32'h7654_AA10);
      do_req(1'b1, 3'b001, 2, 32'h1234_BEEF, 0, 1'b1, 32'hBEEF_AA10);
      do_req(1'b1, 3'b010, 0, 32'h1234_5678, 0, 1'b1, 32'h1234_5678);

`ifdef LSU_MISALIGN_ERR_EN
      do_req(1'b0, 3'b010, 2, 0, 0, 1'b1, 32'h0);
      do_req(1'b0, 3'b001, 1, 0, 0, 1'b1, 32'h0);
`else
      do_req(1'b0, 3'b010, 2, 0, 0, 1'b1, 32'h1234_5678);
      do_req(1'b0, 3'b001, 1, 0, 0, 1'b1, 32'h0000_5678);
`endif

      do_req(1'b0, 3'b010, 4, 0, 5, 1'b1, 32'h0000_80FF);
      do_req(1'b0, 3'b011, 8, 0, 0, 1'b0, 0);

      for (int n = 0; n < 250; n++) begin
         do_req(1'($urandom), 3'($urandom), $urandom_range(0, 63), $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, 0);
      end

      // Reset while the SB is in its read phase: the write must never happen.
      before_word = mword(0);
      resp_ready  = 1'b1;
      req_valid   = 1'b1;
      req_we      = 1'b1;
      req_funct3  = 3'b000;
      req_addr    = 0;
      req_wdata   = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 reset_vals("midrst");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_mem_we", mem_we, 0);
         chk("midrst_resp_valid", resp_valid, 0);
      end
      rst_n = 1'b1;
      chk("midrst_ram_word", ram[0], before_word);
      @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);
      do_req(1'b0, 3'b010, 0, 0, 0, 1'b1, before_word);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
